// File: rtl/demux2_16_buf.sv
// demux2_16_buf: buffered 1:2 demultiplexer for 16-bit words.
// One valid/ready input channel is steered by in_sel into one of two
// independent output channels, each backed by its own 2-entry circular FIFO.
// Optional build macro: DEMUX2_16_ZERO_IDLE_EN forces an output channel's data
// to zero while that channel has no valid word.
module demux2_16_buf (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic        in_sel,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic        o0_valid,
  output logic [15:0] o0_data,
  input  logic        o0_ready,
  output logic        o1_valid,
  output logic [15:0] o1_data,
  input  logic        o1_ready,
  output logic [1:0]  o0_count,
  output logic [1:0]  o1_count
);

  // Per-channel FIFO state, indexed by channel number
  logic [15:0] mem [2][2];
  logic        rd_ptr [2];
  logic        wr_ptr [2];
  logic [1:0]  count [2];
  logic        push [2];
  logic        pop [2];
  logic        out_ready [2];

  assign out_ready[0] = o0_ready;
  assign out_ready[1] = o1_ready;

  // The selected channel's fullness alone decides acceptance; a same-cycle pop does not free a slot
  always_comb begin
    in_ready = ((in_sel ? count[1] : count[0]) != 2'd2);
  end

  // Decode which channel takes the input word and which channels release their head
  always_comb begin
    push[0] = in_valid & in_ready & ~in_sel;
    push[1] = in_valid & in_ready & in_sel;
    pop[0]  = (count[0] != 2'd0) & out_ready[0];
    pop[1]  = (count[1] != 2'd0) & out_ready[1];
  end

  // FIFO storage, pointers and occupancy; reset discards every buffered word at once
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < 2; c++) begin
        mem[c][0] <= 16'h0000;
        mem[c][1] <= 16'h0000;
        rd_ptr[c] <= 1'b0;
        wr_ptr[c] <= 1'b0;
        count[c]  <= 2'd0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (push[c]) begin
          mem[c][wr_ptr[c]] <= in_data;
          wr_ptr[c]         <= ~wr_ptr[c];
        end
        if (pop[c]) begin
          rd_ptr[c] <= ~rd_ptr[c];
        end
        case ({push[c], pop[c]})
          2'b10:   count[c] <= count[c] + 2'd1;
          2'b01:   count[c] <= count[c] - 2'd1;
          default: count[c] <= count[c];
        endcase
      end
    end
  end

  // Head-of-queue presentation; valid and data come from registered state only
  always_comb begin
    o0_valid = (count[0] != 2'd0);
    o1_valid = (count[1] != 2'd0);
    o0_count = count[0];
    o1_count = count[1];
`ifdef DEMUX2_16_ZERO_IDLE_EN
    o0_data  = o0_valid ? mem[0][rd_ptr[0]] : 16'h0000;
    o1_data  = o1_valid ? mem[1][rd_ptr[1]] : 16'h0000;
`else
    o0_data  = mem[0][rd_ptr[0]];
    o1_data  = mem[1][rd_ptr[1]];
`endif
  end

endmodule
